// File: rtl/arc_draw_if.sv
// Sequencer-side bundle of the arc draw engine: draw request, completion,
// and the VGA adapter plot port.
interface arc_draw_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int COLOUR_W = 3
);
  // start/done is a four-phase handshake. The requester raises start with stable
  // operands. The engine latches them at the first edge that samples start high.
  // It raises done on completion and holds it until it samples start low.
  logic                start;
  logic [X_W-1:0]      centre_x;
  logic [Y_W-1:0]      centre_y;
  logic [R_W-1:0]      radius;
  logic [7:0]          octant_mask;
  logic [COLOUR_W-1:0] colour;
  logic                done;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;
  logic [1:0]          dbg_state;

  modport master (
    output start, centre_x, centre_y, radius, octant_mask, colour,
    input  done, vga_x, vga_y, vga_colour, vga_plot, dbg_state
  );

  modport slave (
    input  start, centre_x, centre_y, radius, octant_mask, colour,
    output done, vga_x, vga_y, vga_colour, vga_plot, dbg_state
  );
endinterface

// File: rtl/arc_draw_engine.sv
// Midpoint circle rasteriser. It walks eight octant arcs, spending one cycle per
// octant per step. Each pixel is clipped to the screen and plotted to the VGA adapter.
module arc_draw_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int COLOUR_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  arc_draw_if.slave  bus
);
  localparam int PW = ((X_W > R_W) ? X_W : R_W) + 2;
  localparam int OW = R_W + 2;
  localparam int CW = R_W + 3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1, S_DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [X_W-1:0]        cx_q, cx_d;
  logic [Y_W-1:0]        cy_q, cy_d;
  logic [7:0]            mask_q, mask_d;
  logic [COLOUR_W-1:0]   col_q, col_d;
  logic signed [OW-1:0]  ox_q, ox_d, oy_q, oy_d;
  logic signed [OW-1:0]  oy_inc, ox_dec;
  logic signed [CW-1:0]  crit_q, crit_d;
  logic [2:0]            oct_q, oct_d;
  logic signed [PW-1:0]  cx_s, cy_s, ox_s, oy_s, px, py;
  logic                  on_screen, drawing;

  // ox can go to -1 on the final step of a zero radius, so the offsets are signed.
  always_comb begin
    cx_s = $signed(PW'(cx_q));
    cy_s = $signed(PW'(cy_q));
    ox_s = PW'(ox_q);
    oy_s = PW'(oy_q);
    px   = cx_s;
    py   = cy_s;
    case (oct_q)
      3'd0: begin px = cx_s + ox_s; py = cy_s + oy_s; end
      3'd1: begin px = cx_s + oy_s; py = cy_s + ox_s; end
      3'd2: begin px = cx_s - oy_s; py = cy_s + ox_s; end
      3'd3: begin px = cx_s - ox_s; py = cy_s + oy_s; end
      3'd4: begin px = cx_s - ox_s; py = cy_s - oy_s; end
      3'd5: begin px = cx_s - oy_s; py = cy_s - ox_s; end
      3'd6: begin px = cx_s + oy_s; py = cy_s - ox_s; end
      default: begin px = cx_s + ox_s; py = cy_s - oy_s; end
    endcase
    on_screen = !px[PW-1] && (px < $signed(PW'(SCREEN_W))) &&
                !py[PW-1] && (py < $signed(PW'(SCREEN_H)));
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    mask_d  = mask_q;
    col_d   = col_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    crit_d  = crit_q;
    oct_d   = oct_q;
    oy_inc  = oy_q + OW'(1);
    ox_dec  = ox_q - OW'(1);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cx_d    = bus.centre_x;
          cy_d    = bus.centre_y;
          mask_d  = bus.octant_mask;
          col_d   = bus.colour;
          ox_d    = OW'(bus.radius);
          oy_d    = '0;
          crit_d  = CW'(1) - CW'(bus.radius);
          oct_d   = 3'd0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        oct_d = oct_q + 3'd1;
        // The midpoint step happens once per pass, after the eighth octant.
        if (oct_q == 3'd7) begin
          oy_d = oy_inc;
          if (crit_q[CW-1] || (crit_q == '0)) begin
            crit_d = crit_q + (CW'(oy_inc) <<< 1) + CW'(1);
            if (oy_inc > ox_q) state_d = S_DONE;
          end else begin
            ox_d   = ox_dec;
            crit_d = crit_q + ((CW'(oy_inc) - CW'(ox_dec)) <<< 1) + CW'(1);
            if (oy_inc > ox_dec) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      mask_q  <= '0;
      col_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      crit_q  <= '0;
      oct_q   <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      mask_q  <= mask_d;
      col_q   <= col_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      crit_q  <= crit_d;
      oct_q   <= oct_d;
    end
  end

  // Outputs derive from state, so an asynchronous reset silences them at once.
  assign drawing        = (state_q == S_DRAW);
  assign bus.done       = (state_q == S_DONE);
  assign bus.vga_plot   = drawing && mask_q[oct_q] && on_screen;
  assign bus.vga_x      = drawing ? px[X_W-1:0] : '0;
  assign bus.vga_y      = drawing ? py[Y_W-1:0] : '0;
  assign bus.vga_colour = drawing ? col_q : '0;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_arc_draw_engine.sv
// Directed and randomised checks of arc_draw_engine.
// Each draw is compared cycle by cycle against an integer circle model.
module tb_arc_draw_engine;
  localparam int X_W = 8, Y_W = 7, R_W = 8, COLOUR_W = 3;
  localparam int SCREEN_W = 160, SCREEN_H = 120;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arc_draw_if #(.X_W(X_W), .Y_W(Y_W), .R_W(R_W), .COLOUR_W(COLOUR_W)) bus();

  arc_draw_engine #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
    .X_W(X_W), .Y_W(Y_W), .R_W(R_W), .COLOUR_W(COLOUR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int plot_cnt;
  logic [15:0] exp_q[$];   // {plot, x[7:0], y[6:0]} per DRAW cycle

  int xs[8] = '{1, 1, -1, -1, -1, -1, 1, 1};
  int ys[8] = '{1, 1, 1, 1, -1, -1, -1, -1};
  bit sw[8] = '{0, 1, 1, 0, 0, 1, 1, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Midpoint circle: eight octant points per pass, then one step of the decision variable.
  function automatic void build_model(input int cx, input int cy, input int r, input logic [7:0] mask);
    int ox, oy, crit, px, py;
    logic [31:0] pxu, pyu;
    bit plot, fin;
    exp_q.delete();
    ox = r; oy = 0; crit = 1 - r; fin = 0;
    while (!fin) begin
      for (int o = 0; o < 8; o++) begin
        px = cx + xs[o] * (sw[o] ? oy : ox);
        py = cy + ys[o] * (sw[o] ? ox : oy);
        plot = mask[o] && px >= 0 && px < SCREEN_W && py >= 0 && py < SCREEN_H;
        pxu = px;
        pyu = py;
        exp_q.push_back({plot, pxu[7:0], pyu[6:0]});
      end
      oy = oy + 1;
      if (crit <= 0) crit = crit + 2 * oy + 1;
      else begin
        ox = ox - 1;
        crit = crit + 2 * (oy - ox) + 1;
      end
      if (oy > ox) fin = 1;
    end
  endfunction

  task automatic run_draw(input int cx, input int cy, input int r, input logic [7:0] mask,
                          input logic [2:0] col, input bit scramble);
    logic [15:0] e;
    build_model(cx, cy, r, mask);
    @(negedge clk);
    bus.centre_x    = X_W'(cx);
    bus.centre_y    = Y_W'(cy);
    bus.radius      = R_W'(r);
    bus.octant_mask = mask;
    bus.colour      = col;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    plot_cnt = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      check("plot", bus.vga_plot, e[15]);
      check("x", bus.vga_x, e[14:7]);
      check("y", bus.vga_y, e[6:0]);
      check("colour", bus.vga_colour, col);
      check("done_low", bus.done, 0);
      if (bus.vga_plot) plot_cnt++;
      if (scramble && i == 2) begin
        bus.centre_x    = X_W'($urandom);
        bus.centre_y    = Y_W'($urandom);
        bus.radius      = R_W'($urandom);
        bus.octant_mask = 8'($urandom);
        bus.colour      = COLOUR_W'($urandom);
      end
      @(posedge clk); #1;
    end
    check("done_high", bus.done, 1);
    check("plot_in_done", bus.vga_plot, 0);
    @(posedge clk); #1;
    check("done_hold", bus.done, 1);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("done_fall", bus.done, 0);
    check("idle_state", bus.dbg_state, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.centre_x = '0; bus.centre_y = '0; bus.radius = '0;
    bus.octant_mask = '0; bus.colour = '0;
    #12;
    check("rst_done", bus.done, 0);
    check("rst_plot", bus.vga_plot, 0);
    check("rst_x", bus.vga_x, 0);
    check("rst_y", bus.vga_y, 0);
    check("rst_colour", bus.vga_colour, 0);
    check("rst_state", bus.dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;

    run_draw(80, 60, 0, 8'hFF, 3'd5, 0);
    check("r0_plots", plot_cnt, 8);
    run_draw(80, 60, 1, 8'hFF, 3'd2, 0);
    check("r1_plots", plot_cnt, 16);
    run_draw(80, 60, 40, 8'h01, 3'd7, 0);
    run_draw(80, 60, 40, 8'hFF, 3'd1, 0);
    run_draw(0, 0, 10, 8'hFF, 3'd3, 0);
    run_draw(190, 50, 20, 8'hFF, 3'd6, 0);
    check("offscreen_plots", plot_cnt, 0);

    for (int k = 0; k < 6; k++)
      run_draw($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 60),
               8'($urandom), 3'($urandom), 1);

    // Asynchronous reset in the middle of a draw, then a fresh draw with start still high.
    @(negedge clk);
    bus.centre_x = 8'd80; bus.centre_y = 7'd60; bus.radius = 8'd40;
    bus.octant_mask = 8'hFF; bus.colour = 3'd4; bus.start = 1'b1;
    repeat (50) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_plot", bus.vga_plot, 0);
    check("abort_done", bus.done, 0);
    check("abort_state", bus.dbg_state, 0);
    @(posedge clk); #1;
    check("held_plot", bus.vga_plot, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    run_draw(80, 60, 40, 8'hFF, 3'd4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
